pid_iterm: RTL and testbench

Integral-term generator for the PID controller: accumulates the saturated error samples into a signed integrator and presents a scaled I_term. It consumes the same err_sat/err_vld stream as the derivative block. It decimates that stream, clamps the integrator on overflow (anti-windup) and clears when the platform stops moving. I_term feeds the PID summer in parallel with the P and D terms.

---
 rtl/pid_iterm_if.sv | 29 ++
 rtl/pid_iterm.sv | 102 ++++++++++
 tb/tb_pid_iterm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pid_iterm_if.sv
`default_nettype none
// ============================================================================
//  Module   : pid_iterm_if
//  Brief    : Error-sample stream in, scaled integral term out.
//  Revision : 1.0 - initial release
// ============================================================================
interface pid_iterm_if #(
    parameter int ERR_W     = 10,
    parameter int ACC_W     = 16,
    parameter int OUT_SHIFT = 6
);
    logic signed [ERR_W-1:0]           err_sat;
    logic                              err_vld;
    logic                              moving;
    logic signed [ACC_W-OUT_SHIFT-1:0] I_term;
    logic                              I_vld;
    logic                              sat_flag;

    modport master (
        output err_sat, err_vld, moving,
        input  I_term, I_vld, sat_flag
    );

    modport slave (
        input  err_sat, err_vld, moving,
        output I_term, I_vld, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/pid_iterm.sv
`default_nettype none
// ============================================================================
//  Module   : pid_iterm
//  Brief    : Decimated, anti-windup clamped integrator producing the PID I term.
//  Revision : 1.0 - initial release
// ============================================================================
module pid_iterm #(
    parameter int ERR_W     = 10,
    parameter int ACC_W     = 16,
    parameter int OUT_SHIFT = 6,
    parameter int DECIM     = 4
) (
    input wire          clk,
    input wire          rst_n,
    pid_iterm_if.slave  bus
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SAT  = 2'd2;

    localparam logic signed [ACC_W-1:0] c_pos_rail = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_neg_rail = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              r_state;
    logic                    r_sat;
    logic                    r_vld;

    logic                    w_wrap;
    logic                    w_int;
    logic signed [ACC_W-1:0] w_err_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_rail;

    // Only the pulse that wraps the decimation counter integrates.
    generate
        if (DECIM == 1) begin : g_no_decim
            assign w_wrap = 1'b1;
        end else begin : g_decim
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!bus.moving) begin
                    r_cnt <= '0;
                end else if (bus.err_vld) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_wrap = (r_cnt == CNT_W'(DECIM - 1));
        end
    endgenerate

    assign w_int     = bus.moving && bus.err_vld && w_wrap;
    assign w_err_ext = {{(ACC_W-ERR_W){bus.err_sat[ERR_W-1]}}, bus.err_sat};
    assign w_sum     = r_acc + w_err_ext;
    assign w_ovf     = (r_acc[ACC_W-1] == w_err_ext[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    // Operands share a sign on overflow, so the accumulator sign picks the rail.
    assign w_rail    = r_acc[ACC_W-1] ? c_neg_rail : c_pos_rail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_state <= S_IDLE;
            r_sat   <= 1'b0;
            r_vld   <= 1'b0;
        end else if (!bus.moving) begin
            r_acc   <= '0;
            r_state <= S_IDLE;
            r_sat   <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= w_int;
            if (w_int) begin
                if (w_ovf) begin
                    r_acc   <= w_rail;
                    r_state <= S_SAT;
                    r_sat   <= 1'b1;
                end else begin
                    r_acc   <= w_sum;
                    r_state <= S_RUN;
                    r_sat   <= 1'b0;
                end
            end else if (r_state == S_IDLE) begin
                r_state <= S_RUN;
            end
        end
    end

    assign bus.I_term   = r_acc[ACC_W-1:OUT_SHIFT];
    assign bus.I_vld    = r_vld;
    assign bus.sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_pid_iterm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_iterm
//  Brief    : Scoreboard bench for pid_iterm with directed error sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_iterm;

    localparam int ERR_W     = 10;
    localparam int ACC_W     = 16;
    localparam int OUT_SHIFT = 6;
    localparam int DECIM     = 4;
    localparam int IT_W      = ACC_W - OUT_SHIFT;

    typedef struct {
        logic [IT_W-1:0] iterm;
        logic            sat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pid_iterm_if #(.ERR_W(ERR_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) bus ();

    pid_iterm #(
        .ERR_W(ERR_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .DECIM(DECIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_acc    = 0;
    int   m_cnt    = 0;

    // Monitor: every I_vld must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.I_vld === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_I_vld actual I_term=%0d required no pulse", bus.I_term);
            end else begin
                e_mon = sb.pop_front();
                if (bus.I_term !== e_mon.iterm || bus.sat_flag !== e_mon.sat) begin
                    n_errors++;
                    $display("FAIL scoreboard actual I_term=%h sat=%b required I_term=%h sat=%b",
                             bus.I_term, bus.sat_flag, e_mon.iterm, e_mon.sat);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_integrate(input int e);
        int   s;
        exp_t x;
        s = m_acc + e;
        if (s > 32767) begin
            m_acc = 32767;  x.sat = 1'b1;
        end else if (s < -32768) begin
            m_acc = -32768; x.sat = 1'b1;
        end else begin
            m_acc = s;      x.sat = 1'b0;
        end
        x.iterm = IT_W'(m_acc >>> OUT_SHIFT);
        sb.push_back(x);
    endtask

    // Called at posedge+1; occupies exactly one cycle so calls chain back-to-back.
    task automatic pulse(input int e, input bit mv);
        bus.err_sat = ERR_W'(e);
        bus.err_vld = 1'b1;
        bus.moving  = mv;
        if (mv) begin
            m_cnt = (m_cnt + 1) % DECIM;
            if (m_cnt == 0) model_integrate(e);
        end else begin
            m_acc = 0;
            m_cnt = 0;
        end
        @(posedge clk); #1;
        bus.err_vld = 1'b0;
    endtask

    task automatic integr(input int n, input int e);
        repeat (n * DECIM) pulse(e, 1'b1);
    endtask

    task automatic clear();
        bus.moving = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk); #1;
        bus.moving = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.err_sat = '0;
        bus.err_vld = 1'b0;
        bus.moving  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_iterm", bus.I_term, 0);
        chk("reset_vld",   bus.I_vld, 0);
        chk("reset_sat",   bus.sat_flag, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bus.moving = 1'b1;

        // Basic accumulate: 4 x 100 -> 100, I_term 1
        integr(1, 100);
        @(negedge clk);
        chk("basic_iterm", bus.I_term, 1);

        // Negative floor: -1 -> I_term -1
        clear();
        integr(1, -1);
        @(negedge clk);
        chk("floor_iterm", bus.I_term, -1);
        chk("floor_sat",   bus.sat_flag, 0);

        // Positive overflow
        clear();
        integr(64, 511);
        @(negedge clk);
        chk("pos_32704_iterm", bus.I_term, 511);
        chk("pos_32704_sat",   bus.sat_flag, 0);
        @(posedge clk); #1;
        integr(1, 511);
        @(negedge clk);
        chk("pos_clamp_iterm", bus.I_term, 511);
        chk("pos_clamp_sat",   bus.sat_flag, 1);
        @(posedge clk); #1;
        integr(1, -512);
        @(negedge clk);
        chk("pos_release_iterm", bus.I_term, 503);
        chk("pos_release_sat",   bus.sat_flag, 0);

        // Negative overflow
        @(posedge clk); #1;
        clear();
        chk("clear_sat", bus.sat_flag, 0);
        integr(65, -512);
        @(negedge clk);
        chk("neg_clamp_iterm", bus.I_term, -512);
        chk("neg_clamp_sat",   bus.sat_flag, 1);
        @(posedge clk); #1;
        integr(1, -512);
        @(negedge clk);
        chk("neg_reclamp_iterm", bus.I_term, -512);
        chk("neg_reclamp_sat",   bus.sat_flag, 1);

        // Clear priority over a coincident 4th pulse
        @(posedge clk); #1;
        clear();
        integr(10, 500);
        @(negedge clk);
        chk("pre_clear_iterm", bus.I_term, 78);
        @(posedge clk); #1;
        repeat (3) pulse(0, 1'b1);
        pulse(0, 1'b0);
        @(negedge clk);
        chk("clear_prio_iterm", bus.I_term, 0);
        chk("clear_prio_vld",   bus.I_vld, 0);
        @(posedge clk); #1;
        integr(1, 64);
        @(negedge clk);
        chk("after_clear_iterm", bus.I_term, 1);

        // Asynchronous reset between 2nd and 3rd pulses
        @(posedge clk); #1;
        pulse(200, 1'b1);
        pulse(200, 1'b1);
        #3;
        rst_n = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        #1;
        chk("async_iterm", bus.I_term, 0);
        chk("async_vld",   bus.I_vld, 0);
        chk("async_sat",   bus.sat_flag, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        integr(1, 200);
        @(negedge clk);
        chk("post_reset_iterm", bus.I_term, 3);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
